// File: rtl/spike_aer_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : spike_aer_encoder_if
//  Brief    : Address-event stream bus (valid/ready) from the spike encoder
//             to its consumer.
//  Revision : 1.0 - initial release
// ============================================================================
interface spike_aer_encoder_if #(
    parameter int NID_W = 8,
    parameter int TS_W  = 2
);
    logic                    aer_valid;
    logic                    aer_ready;
    logic [NID_W+TS_W-1:0]   aer_addr;
    logic                    aer_last;

    modport master (
        output aer_valid,
        output aer_addr,
        output aer_last,
        input  aer_ready
    );

    modport slave (
        input  aer_valid,
        input  aer_addr,
        input  aer_last,
        output aer_ready
    );
endinterface
`default_nettype wire

// File: rtl/spike_aer_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : spike_aer_encoder
//  Brief    : Buffers LIF spike vectors in a small FIFO and serialises them
//             into one {neuron_id, timestep} address event per spike.
//  Revision : 1.0 - initial release
// ============================================================================
module spike_aer_encoder #(
    parameter int T     = 4,
    parameter int NID_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              lif_done,
    input  wire logic [T-1:0]      spike_in,
    input  wire logic [NID_W-1:0]  neuron_id,
    spike_aer_encoder_if.master    aer,
    output logic                   fifo_empty,
    output logic                   overflow,
    output logic [CNT_W-1:0]       event_count,
    output logic [CNT_W-1:0]       drop_count
);

    localparam int TS_W  = $clog2(T);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = NID_W + T;

    localparam logic [PTR_W:0]   c_DEPTH_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   c_CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] c_PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [T-1:0]     c_VEC_ONE   = {{(T-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_STAT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_EMIT = 1'b1;

    // FIFO storage and bookkeeping
    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    // Emission state
    logic [0:0]        r_state;
    logic [T-1:0]      r_vec;
    logic [NID_W-1:0]  r_id;

    logic              r_overflow;
    logic [CNT_W-1:0]  r_event_count;
    logic [CNT_W-1:0]  r_drop_count;

    logic              w_valid;
    logic              w_fire;
    logic              w_last;
    logic [TS_W-1:0]   w_ts;
    logic [T-1:0]      w_vec_next;
    logic              w_nonempty;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push;
    logic              w_drop;
    logic [NID_W-1:0]  w_head_id;
    logic [T-1:0]      w_head_vec;

    assign w_valid    = (r_state == c_ST_EMIT);
    assign w_fire     = w_valid && aer.aer_ready;
    assign w_vec_next = r_vec & (r_vec - c_VEC_ONE);
    assign w_last     = (r_vec != '0) && (w_vec_next == '0);
    assign w_nonempty = (r_count != '0);

    // Pop on an idle FSM, or chained onto the final event of a vector so
    // back-to-back vectors stream without a bubble.
    assign w_pop      = w_nonempty && ((r_state == c_ST_IDLE) || (w_fire && w_last));

    // A full FIFO still accepts a vector when a pop frees a slot at the same edge.
    assign w_push_req = lif_done && (spike_in != '0);
    assign w_push     = w_push_req && ((r_count != c_DEPTH_CNT) || w_pop);
    assign w_drop     = w_push_req && !w_push;

    assign {w_head_id, w_head_vec} = r_mem[r_rd_ptr];

    // Lowest set bit of the remaining spike vector selects the timestep.
    always_comb begin
        w_ts = '0;
        for (int i = T - 1; i >= 0; i--) begin
            if (r_vec[i]) begin
                w_ts = TS_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {neuron_id, spike_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_vec   <= '0;
            r_id    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= c_ST_EMIT;
                        r_vec   <= w_head_vec;
                        r_id    <= w_head_id;
                    end
                end
                c_ST_EMIT: begin
                    if (w_fire) begin
                        if (!w_last) begin
                            r_vec <= w_vec_next;
                        end else if (w_pop) begin
                            r_vec <= w_head_vec;
                            r_id  <= w_head_id;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_vec   <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_vec   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow    <= 1'b0;
            r_event_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_fire && (r_event_count != '1)) begin
                r_event_count <= r_event_count + c_STAT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + c_STAT_ONE;
                end
            end
        end
    end

    assign aer.aer_valid = w_valid;
    assign aer.aer_addr  = {r_id, w_ts};
    assign aer.aer_last  = w_last;

    assign fifo_empty  = !w_nonempty;
    assign overflow    = r_overflow;
    assign event_count = r_event_count;
    assign drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_spike_aer_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spike_aer_encoder
//  Brief    : Directed self-checking bench for spike_aer_encoder (T=4, DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spike_aer_encoder;

    localparam int T     = 4;
    localparam int NID_W = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int TS_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              lif_done;
    logic [T-1:0]      spike_in;
    logic [NID_W-1:0]  neuron_id;
    logic              fifo_empty;
    logic              overflow;
    logic [CNT_W-1:0]  event_count;
    logic [CNT_W-1:0]  drop_count;

    int n_total = 0;
    int n_bad   = 0;

    spike_aer_encoder_if #(.NID_W(NID_W), .TS_W(TS_W)) aer_bus ();

    spike_aer_encoder #(
        .T     (T),
        .NID_W (NID_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lif_done    (lif_done),
        .spike_in    (spike_in),
        .neuron_id   (neuron_id),
        .aer         (aer_bus),
        .fifo_empty  (fifo_empty),
        .overflow    (overflow),
        .event_count (event_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {neuron_id, timestep} with TS_W = 2
    function automatic logic [31:0] ev(input int id, input int ts);
        return 32'(id * 4 + ts);
    endfunction

    initial begin
        rst               = 1'b1;
        lif_done          = 1'b0;
        spike_in          = '0;
        neuron_id         = '0;
        aer_bus.aer_ready = 1'b0;
        tick();
        tick();
        chk("rst valid", 32'(aer_bus.aer_valid), 0);
        chk("rst addr",  32'(aer_bus.aer_addr),  0);
        chk("rst last",  32'(aer_bus.aer_last),  0);
        chk("rst empty", 32'(fifo_empty),        1);
        chk("rst ovf",   32'(overflow),          0);
        chk("rst evcnt", 32'(event_count),       0);
        chk("rst drcnt", 32'(drop_count),        0);
        rst = 1'b0;

        // 1: two spikes from neuron 5
        aer_bus.aer_ready = 1'b1;
        lif_done = 1'b1; neuron_id = 8'd5; spike_in = 4'b1010;
        tick();
        lif_done = 1'b0; spike_in = '0;
        chk("t1 valid0", 32'(aer_bus.aer_valid), 0);
        chk("t1 nonempty", 32'(fifo_empty), 0);
        tick();
        chk("t1 valid1", 32'(aer_bus.aer_valid), 1);
        chk("t1 ev0",    32'(aer_bus.aer_addr),  ev(5, 1));
        chk("t1 last0",  32'(aer_bus.aer_last),  0);
        tick();
        chk("t1 ev1",    32'(aer_bus.aer_addr),  ev(5, 3));
        chk("t1 last1",  32'(aer_bus.aer_last),  1);
        tick();
        chk("t1 idle",   32'(aer_bus.aer_valid), 0);
        chk("t1 evcnt",  32'(event_count),       2);
        chk("t1 empty",  32'(fifo_empty),        1);

        // 2: an all-zero vector is ignored
        lif_done = 1'b1; neuron_id = 8'd7; spike_in = 4'b0000;
        tick();
        lif_done = 1'b0;
        chk("t2 empty",  32'(fifo_empty), 1);
        tick();
        chk("t2 valid",  32'(aer_bus.aer_valid), 0);
        chk("t2 drcnt",  32'(drop_count),  0);
        chk("t2 evcnt",  32'(event_count), 2);

        // 3: backpressure holds the event stable
        aer_bus.aer_ready = 1'b0;
        lif_done = 1'b1; neuron_id = 8'd9; spike_in = 4'b0110;
        tick();
        lif_done = 1'b0; spike_in = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3 hold valid", 32'(aer_bus.aer_valid), 1);
            chk("t3 hold addr",  32'(aer_bus.aer_addr),  ev(9, 1));
            chk("t3 hold last",  32'(aer_bus.aer_last),  0);
        end
        aer_bus.aer_ready = 1'b1;
        tick();
        chk("t3 ev1",   32'(aer_bus.aer_addr), ev(9, 2));
        chk("t3 last1", 32'(aer_bus.aer_last), 1);
        tick();
        chk("t3 idle",  32'(aer_bus.aer_valid), 0);
        chk("t3 evcnt", 32'(event_count), 4);

        // 4: park id 8 in the emitter, then overfill the FIFO with ids 1..5
        aer_bus.aer_ready = 1'b0;
        lif_done = 1'b1; neuron_id = 8'd8; spike_in = 4'b0001;
        tick();
        lif_done = 1'b0;
        tick();
        chk("t4 park", 32'(aer_bus.aer_addr), ev(8, 0));
        for (int i = 1; i <= 5; i++) begin
            lif_done  = 1'b1;
            neuron_id = 8'(i);
            spike_in  = 4'(1 << (i % 4));
            tick();
        end
        lif_done = 1'b0; spike_in = '0;
        chk("t4 ovf",   32'(overflow),   1);
        chk("t4 drcnt", 32'(drop_count), 1);
        chk("t4 still", 32'(aer_bus.aer_addr), ev(8, 0));
        aer_bus.aer_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t4 drain valid", 32'(aer_bus.aer_valid), 1);
            chk("t4 drain addr",  32'(aer_bus.aer_addr),  ev(i, i % 4));
        end
        tick();
        chk("t4 idle",  32'(aer_bus.aer_valid), 0);
        chk("t4 empty", 32'(fifo_empty), 1);
        chk("t4 evcnt", 32'(event_count), 9);

        // 5: single-spike vectors chain without a bubble
        lif_done = 1'b1; neuron_id = 8'd2; spike_in = 4'b1000;
        tick();
        neuron_id = 8'd3; spike_in = 4'b0001;
        chk("t5 valid0", 32'(aer_bus.aer_valid), 0);
        tick();
        lif_done = 1'b0; spike_in = '0;
        chk("t5 ev0",   32'(aer_bus.aer_addr), ev(2, 3));
        chk("t5 last0", 32'(aer_bus.aer_last), 1);
        tick();
        chk("t5 valid1", 32'(aer_bus.aer_valid), 1);
        chk("t5 ev1",    32'(aer_bus.aer_addr),  ev(3, 0));
        chk("t5 last1",  32'(aer_bus.aer_last),  1);
        tick();
        chk("t5 idle",  32'(aer_bus.aer_valid), 0);
        chk("t5 evcnt", 32'(event_count), 11);

        // 6: reset in the middle of an emission with two vectors queued
        aer_bus.aer_ready = 1'b0;
        lif_done = 1'b1; neuron_id = 8'd6; spike_in = 4'b0011;
        tick();
        neuron_id = 8'd7; spike_in = 4'b0001;
        tick();
        neuron_id = 8'd10; spike_in = 4'b0001;
        tick();
        lif_done = 1'b0; spike_in = '0;
        chk("t6 pre valid", 32'(aer_bus.aer_valid), 1);
        chk("t6 pre addr",  32'(aer_bus.aer_addr),  ev(6, 0));
        chk("t6 pre empty", 32'(fifo_empty), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 valid", 32'(aer_bus.aer_valid), 0);
        chk("t6 addr",  32'(aer_bus.aer_addr),  0);
        chk("t6 empty", 32'(fifo_empty),  1);
        chk("t6 evcnt", 32'(event_count), 0);
        chk("t6 drcnt", 32'(drop_count),  0);
        chk("t6 ovf",   32'(overflow),    0);
        aer_bus.aer_ready = 1'b1;
        tick();
        chk("t6 stays idle", 32'(aer_bus.aer_valid), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
